// File: rtl/keypad_pkg.sv
// Shared key codes, lock FSM state encoding and key classification for the keypad lock.
package keypad_pkg;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_BACK  = 4'hB;
  localparam logic [3:0] KEY_PROG  = 4'hC;
  localparam logic [3:0] KEY_CLEAR = 4'hE;
  localparam logic [3:0] KEY_NONE  = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    CHECK,
    OPEN,
    LOCKOUT,
    PROG
  } lock_state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/keypad_code_lock_ms_tick_gen.sv
// Free-running divider: one-cycle registered tick every CLK_HZ/1000 clocks (1 ms).
module ms_tick_gen #(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned DIV = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == CW'(DIV - 1)) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/keypad_code_lock.sv
// PIN-entry lock fed by keypad_scanner strobes; timed unlock and lockout.
// Optional code programming from OPEN is enabled by defining KEYPAD_LOCK_PROGRAM_EN.
module keypad_code_lock
  import keypad_pkg::*;
#(
  parameter int unsigned          CODE_LEN         = 4,
  parameter int unsigned          CLK_HZ           = 50000000,
  parameter int unsigned          ENTRY_TIMEOUT_MS = 5000,
  parameter int unsigned          UNLOCK_MS        = 3000,
  parameter int unsigned          MAX_FAILS        = 3,
  parameter int unsigned          LOCKOUT_MS       = 10000,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE    = 16'h1234
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             key_valid,
  input  logic [3:0]                       key_value,
  output logic [4*CODE_LEN-1:0]            entry_digits,
  output logic [$clog2(CODE_LEN+1)-1:0]    digit_count,
  output logic                             unlocked,
  output logic                             locked_out,
  output logic                             good_code,
  output logic                             bad_code,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count,
  output logic                             prog_active
);

  localparam int unsigned DW     = 4 * CODE_LEN;
  localparam int unsigned CW     = $clog2(CODE_LEN + 1);
  localparam int unsigned FW     = $clog2(MAX_FAILS + 1);
  localparam int unsigned MAX_A  = (ENTRY_TIMEOUT_MS > UNLOCK_MS) ? ENTRY_TIMEOUT_MS : UNLOCK_MS;
  localparam int unsigned MAX_MS = (MAX_A > LOCKOUT_MS) ? MAX_A : LOCKOUT_MS;
  localparam int unsigned MSW    = $clog2(MAX_MS + 1);

  lock_state_t   r_state;
  logic          r_kv;
  logic [3:0]    r_key;
  logic [DW-1:0] r_digits;
  logic [DW-1:0] r_code;
  logic [CW-1:0] r_count;
  logic [FW-1:0] r_fail;
  logic [MSW-1:0] r_ms;
  logic          r_good;
  logic          r_bad;
  logic          r_unlocked;
  logic          r_locked;
`ifdef KEYPAD_LOCK_PROGRAM_EN
  logic          r_prog;
`endif

  logic          w_tick;
  logic          w_full;
  logic [DW-1:0] w_shl;
  logic [DW-1:0] w_shr;

  ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  assign w_full = (r_count == CW'(CODE_LEN));
  assign w_shl  = (r_digits << 4) | DW'(r_key);
  assign w_shr  = r_digits >> 4;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_kv       <= 1'b0;
      r_key      <= KEY_NONE;
      r_digits   <= '0;
      r_code     <= DEFAULT_CODE;
      r_count    <= '0;
      r_fail     <= '0;
      r_ms       <= '0;
      r_good     <= 1'b0;
      r_bad      <= 1'b0;
      r_unlocked <= 1'b0;
      r_locked   <= 1'b0;
`ifdef KEYPAD_LOCK_PROGRAM_EN
      r_prog     <= 1'b0;
`endif
    end else begin
      r_kv   <= key_valid;
      r_key  <= key_value;
      r_good <= 1'b0;
      r_bad  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ms <= '0;
          if (r_kv && is_digit(r_key)) begin
            r_digits <= DW'(r_key);
            r_count  <= CW'(1);
            r_state  <= ENTRY;
          end
        end
        ENTRY: begin
          // Any strobe restarts the idle timer and wins over an expiring timeout.
          if (r_kv) begin
            r_ms <= '0;
            if (is_digit(r_key)) begin
              if (!w_full) begin
                r_digits <= w_shl;
                r_count  <= r_count + 1'b1;
              end
            end else if (r_key == KEY_BACK) begin
              r_digits <= w_shr;
              r_count  <= r_count - 1'b1;
              if (r_count == CW'(1)) r_state <= IDLE;
            end else if (r_key == KEY_CLEAR) begin
              r_digits <= '0;
              r_count  <= '0;
              r_state  <= IDLE;
            end else if (r_key == KEY_ENTER) begin
              r_state <= CHECK;
            end
          end else if (w_tick) begin
            if (r_ms == MSW'(ENTRY_TIMEOUT_MS - 1)) begin
              r_digits <= '0;
              r_count  <= '0;
              r_ms     <= '0;
              r_state  <= IDLE;
            end else begin
              r_ms <= r_ms + 1'b1;
            end
          end
        end
        CHECK: begin
          r_digits <= '0;
          r_count  <= '0;
          r_ms     <= '0;
          if (w_full && (r_digits == r_code)) begin
            r_good     <= 1'b1;
            r_fail     <= '0;
            r_unlocked <= 1'b1;
            r_state    <= OPEN;
          end else begin
            r_bad  <= 1'b1;
            r_fail <= r_fail + 1'b1;
            if (r_fail == FW'(MAX_FAILS - 1)) begin
              r_locked <= 1'b1;
              r_state  <= LOCKOUT;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        OPEN: begin
          if (r_kv && (r_key == KEY_CLEAR)) begin
            r_unlocked <= 1'b0;
            r_ms       <= '0;
            r_state    <= IDLE;
`ifdef KEYPAD_LOCK_PROGRAM_EN
          end else if (r_kv && (r_key == KEY_PROG)) begin
            r_unlocked <= 1'b0;
            r_prog     <= 1'b1;
            r_digits   <= '0;
            r_count    <= '0;
            r_ms       <= '0;
            r_state    <= PROG;
`endif
          end else if (w_tick) begin
            if (r_ms == MSW'(UNLOCK_MS - 1)) begin
              r_unlocked <= 1'b0;
              r_ms       <= '0;
              r_state    <= IDLE;
            end else begin
              r_ms <= r_ms + 1'b1;
            end
          end
        end
        LOCKOUT: begin
          if (w_tick) begin
            if (r_ms == MSW'(LOCKOUT_MS - 1)) begin
              r_locked <= 1'b0;
              r_fail   <= '0;
              r_ms     <= '0;
              r_state  <= IDLE;
            end else begin
              r_ms <= r_ms + 1'b1;
            end
          end
        end
`ifdef KEYPAD_LOCK_PROGRAM_EN
        PROG: begin
          if (r_kv) begin
            r_ms <= '0;
            if (is_digit(r_key)) begin
              if (!w_full) begin
                r_digits <= w_shl;
                r_count  <= r_count + 1'b1;
              end
            end else if ((r_key == KEY_BACK) && (r_count != '0)) begin
              r_digits <= w_shr;
              r_count  <= r_count - 1'b1;
              if (r_count == CW'(1)) begin
                r_prog  <= 1'b0;
                r_state <= IDLE;
              end
            end else if ((r_key == KEY_CLEAR) || (r_key == KEY_ENTER)) begin
              if (r_key == KEY_ENTER) begin
                if (w_full) begin
                  r_code <= r_digits;
                  r_good <= 1'b1;
                end else begin
                  r_bad <= 1'b1;
                end
              end
              r_digits <= '0;
              r_count  <= '0;
              r_prog   <= 1'b0;
              r_state  <= IDLE;
            end
          end else if (w_tick) begin
            if (r_ms == MSW'(ENTRY_TIMEOUT_MS - 1)) begin
              r_digits <= '0;
              r_count  <= '0;
              r_ms     <= '0;
              r_prog   <= 1'b0;
              r_state  <= IDLE;
            end else begin
              r_ms <= r_ms + 1'b1;
            end
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign entry_digits = r_digits;
  assign digit_count  = r_count;
  assign unlocked     = r_unlocked;
  assign locked_out   = r_locked;
  assign good_code    = r_good;
  assign bad_code     = r_bad;
  assign fail_count   = r_fail;
`ifdef KEYPAD_LOCK_PROGRAM_EN
  assign prog_active  = r_prog;
`else
  assign prog_active  = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_code_lock.sv
// Directed bench for keypad_code_lock with 1 ms = 1 clock; programming test runs when KEYPAD_LOCK_PROGRAM_EN is defined.
module tb_keypad_code_lock;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_value;
  logic [15:0] entry_digits;
  logic [2:0]  digit_count;
  logic        unlocked;
  logic        locked_out;
  logic        good_code;
  logic        bad_code;
  logic [1:0]  fail_count;
  logic        prog_active;

  int total = 0;
  int errs  = 0;
  int cnt_good = 0, cnt_bad = 0, cnt_unl = 0, cnt_lock = 0;

  always #5 clk = ~clk;

  keypad_code_lock #(
    .CODE_LEN         (4),
    .CLK_HZ           (1000),
    .ENTRY_TIMEOUT_MS (20),
    .UNLOCK_MS        (10),
    .MAX_FAILS        (3),
    .LOCKOUT_MS       (30),
    .DEFAULT_CODE     (16'h1234)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_valid    (key_valid),
    .key_value    (key_value),
    .entry_digits (entry_digits),
    .digit_count  (digit_count),
    .unlocked     (unlocked),
    .locked_out   (locked_out),
    .good_code    (good_code),
    .bad_code     (bad_code),
    .fail_count   (fail_count),
    .prog_active  (prog_active)
  );

  // Pulse and level counters sampled on the falling edge.
  always @(negedge clk) begin
    if (good_code === 1'b1)  cnt_good++;
    if (bad_code === 1'b1)   cnt_bad++;
    if (unlocked === 1'b1)   cnt_unl++;
    if (locked_out === 1'b1) cnt_lock++;
  end

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_value = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_value = 4'hF;
  endtask

  task automatic press_code(input logic [15:0] code);
    logic [15:0] c;
    c = code;
    for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
    press(4'hA);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    key_valid = 1'b0;
    key_value = 4'hF;
    idle(3);
    total++;
    if ({unlocked, locked_out, good_code, bad_code, prog_active} !== 5'b0) begin
      errs++; $display("FAIL reset_flags: got %b want 00000", {unlocked, locked_out, good_code, bad_code, prog_active});
    end
    total++;
    if ({entry_digits, digit_count, fail_count} !== 21'h0) begin
      errs++; $display("FAIL reset_buffer: got digits=%h count=%0d fails=%0d want 0", entry_digits, digit_count, fail_count);
    end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_unlock;
    int g0, b0, u0;
    g0 = cnt_good; b0 = cnt_bad; u0 = cnt_unl;
    press_code(16'h1234);
    idle(3);
    total++;
    if (unlocked !== 1'b1) begin errs++; $display("FAIL unlock_open: got %b want 1", unlocked); end
    total++;
    if (cnt_good - g0 != 1) begin errs++; $display("FAIL unlock_good_pulses: got %0d want 1", cnt_good - g0); end
    idle(15);
    total++;
    if (cnt_unl - u0 != 10) begin errs++; $display("FAIL unlock_hold_cycles: got %0d want 10", cnt_unl - u0); end
    total++;
    if ({unlocked, fail_count} !== 3'b0) begin errs++; $display("FAIL unlock_after: got unl=%b fails=%0d want 0", unlocked, fail_count); end
    total++;
    if (cnt_bad != b0) begin errs++; $display("FAIL unlock_no_bad: got %0d want %0d", cnt_bad, b0); end
  endtask

  task automatic test_lockout;
    int g0, b0, l0;
    g0 = cnt_good; b0 = cnt_bad; l0 = cnt_lock;
    for (int i = 0; i < 3; i++) begin
      press_code(16'h1235);
      idle(3);
      total++;
      if (fail_count !== 2'(i + 1) || locked_out !== (i == 2)) begin
        errs++; $display("FAIL lockout_try%0d: got fails=%0d lk=%b want fails=%0d lk=%b", i, fail_count, locked_out, i + 1, i == 2);
      end
    end
    total++;
    if (cnt_bad - b0 != 3) begin errs++; $display("FAIL lockout_bad_pulses: got %0d want 3", cnt_bad - b0); end
    press_code(16'h1234);
    idle(2);
    total++;
    if (locked_out !== 1'b1 || unlocked !== 1'b0 || cnt_good != g0) begin
      errs++; $display("FAIL lockout_ignores_keys: got lk=%b unl=%b good=%0d want 1 0 0", locked_out, unlocked, cnt_good - g0);
    end
    for (int i = 0; i < 60 && locked_out === 1'b1; i++) @(negedge clk);
    total++;
    if (locked_out !== 1'b0) begin errs++; $display("FAIL lockout_release: got %b want 0", locked_out); end
    idle(2);
    total++;
    if (cnt_lock - l0 != 30) begin errs++; $display("FAIL lockout_cycles: got %0d want 30", cnt_lock - l0); end
    total++;
    if (fail_count !== 2'd0) begin errs++; $display("FAIL lockout_fail_clear: got %0d want 0", fail_count); end
    press_code(16'h1234);
    idle(3);
    total++;
    if (unlocked !== 1'b1 || cnt_good - g0 != 1) begin
      errs++; $display("FAIL lockout_then_unlock: got unl=%b good=%0d want 1 1", unlocked, cnt_good - g0);
    end
    idle(15);
  endtask

  task automatic test_digits;
    int b0;
    b0 = cnt_bad;
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
    idle(2);
    total++;
    if (digit_count !== 3'd4 || entry_digits !== 16'h1234) begin
      errs++; $display("FAIL digits_full: got cnt=%0d dig=%h want 4 1234", digit_count, entry_digits);
    end
    press(4'hB);
    idle(2);
    total++;
    if (digit_count !== 3'd3 || entry_digits !== 16'h0123) begin
      errs++; $display("FAIL digits_back: got cnt=%0d dig=%h want 3 0123", digit_count, entry_digits);
    end
    press(4'h9);
    idle(2);
    total++;
    if (digit_count !== 3'd4 || entry_digits !== 16'h1239) begin
      errs++; $display("FAIL digits_replace: got cnt=%0d dig=%h want 4 1239", digit_count, entry_digits);
    end
    press(4'hE);
    idle(2);
    total++;
    if (digit_count !== 3'd0 || entry_digits !== 16'h0) begin
      errs++; $display("FAIL digits_clear: got cnt=%0d dig=%h want 0 0000", digit_count, entry_digits);
    end
    press(4'hA);
    idle(3);
    total++;
    if (cnt_bad != b0) begin errs++; $display("FAIL digits_idle_enter: got %0d want 0", cnt_bad - b0); end
  endtask

  task automatic test_timeout;
    int g0, b0;
    g0 = cnt_good; b0 = cnt_bad;
    press(4'h1); press(4'h2);
    idle(15);
    total++;
    if (digit_count !== 3'd2 || entry_digits !== 16'h0012) begin
      errs++; $display("FAIL timeout_before: got cnt=%0d dig=%h want 2 0012", digit_count, entry_digits);
    end
    idle(10);
    total++;
    if (digit_count !== 3'd0 || entry_digits !== 16'h0) begin
      errs++; $display("FAIL timeout_expired: got cnt=%0d dig=%h want 0 0000", digit_count, entry_digits);
    end
    press(4'hA);
    idle(3);
    total++;
    if (cnt_good != g0 || cnt_bad != b0) begin
      errs++; $display("FAIL timeout_enter_ignored: got good=%0d bad=%0d want 0 0", cnt_good - g0, cnt_bad - b0);
    end
  endtask

  task automatic test_short_code;
    int b0;
    b0 = cnt_bad;
    press(4'h1); press(4'h2); press(4'hA);
    idle(3);
    total++;
    if (cnt_bad - b0 != 1 || fail_count !== 2'd1 || digit_count !== 3'd0) begin
      errs++; $display("FAIL short_code: got bad=%0d fails=%0d cnt=%0d want 1 1 0", cnt_bad - b0, fail_count, digit_count);
    end
    press_code(16'h1234);
    idle(3);
    total++;
    if (unlocked !== 1'b1 || fail_count !== 2'd0) begin
      errs++; $display("FAIL short_then_good: got unl=%b fails=%0d want 1 0", unlocked, fail_count);
    end
    press(4'hE);
    idle(2);
    total++;
    if (unlocked !== 1'b0) begin errs++; $display("FAIL open_clear: got %b want 0", unlocked); end
  endtask

  task automatic test_back_to_idle;
    int b0;
    b0 = cnt_bad;
    press(4'h7); press(4'hB);
    idle(2);
    press(4'hA);
    idle(3);
    total++;
    if (digit_count !== 3'd0 || cnt_bad != b0) begin
      errs++; $display("FAIL back_to_idle: got cnt=%0d bad=%0d want 0 0", digit_count, cnt_bad - b0);
    end
    press(4'h1); press(4'hD); press(4'hF); press(4'hC);
    idle(2);
    total++;
    if (digit_count !== 3'd1 || entry_digits !== 16'h0001) begin
      errs++; $display("FAIL ignored_keys: got cnt=%0d dig=%h want 1 0001", digit_count, entry_digits);
    end
    press(4'hE);
    idle(2);
  endtask

  task automatic test_reset_midway;
    press_code(16'h1235);
    idle(3);
    press(4'h5); press(4'h6);
    idle(1);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    total++;
    if ({fail_count, digit_count, entry_digits} !== 21'h0) begin
      errs++; $display("FAIL reset_midway: got fails=%0d cnt=%0d dig=%h want 0", fail_count, digit_count, entry_digits);
    end
    idle(2);
  endtask

`ifdef KEYPAD_LOCK_PROGRAM_EN
  task automatic test_prog;
    int g0, b0;
    press_code(16'h1234);
    idle(3);
    press(4'hC);
    idle(2);
    total++;
    if (prog_active !== 1'b1 || unlocked !== 1'b0 || digit_count !== 3'd0) begin
      errs++; $display("FAIL prog_enter: got prog=%b unl=%b cnt=%0d want 1 0 0", prog_active, unlocked, digit_count);
    end
    g0 = cnt_good; b0 = cnt_bad;
    press_code(16'h9876);
    idle(2);
    total++;
    if (cnt_good - g0 != 1 || prog_active !== 1'b0) begin
      errs++; $display("FAIL prog_write: got good=%0d prog=%b want 1 0", cnt_good - g0, prog_active);
    end
    press_code(16'h1234);
    idle(3);
    total++;
    if (cnt_bad - b0 != 1 || unlocked !== 1'b0) begin
      errs++; $display("FAIL prog_old_code: got bad=%0d unl=%b want 1 0", cnt_bad - b0, unlocked);
    end
    press_code(16'h9876);
    idle(3);
    total++;
    if (unlocked !== 1'b1 || fail_count !== 2'd0) begin
      errs++; $display("FAIL prog_new_code: got unl=%b fails=%0d want 1 0", unlocked, fail_count);
    end
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    press_code(16'h1234);
    idle(3);
    total++;
    if (unlocked !== 1'b1) begin errs++; $display("FAIL prog_reset_default: got %b want 1", unlocked); end
    idle(15);
  endtask
`else
  task automatic test_prog_absent;
    press_code(16'h1234);
    idle(3);
    press(4'hC);
    idle(2);
    total++;
    if (unlocked !== 1'b1 || prog_active !== 1'b0) begin
      errs++; $display("FAIL prog_key_ignored: got unl=%b prog=%b want 1 0", unlocked, prog_active);
    end
    idle(15);
  endtask
`endif

  initial begin
    test_reset;
    test_unlock;
    test_lockout;
    test_digits;
    test_timeout;
    test_short_code;
    test_back_to_idle;
    test_reset_midway;
`ifdef KEYPAD_LOCK_PROGRAM_EN
    test_prog;
`else
    test_prog_absent;
`endif
    $display("test done: total=%0d bad=%0d", total, errs);
    $finish;
  end

endmodule

// File: doc/keypad_code_lock.md
Name: keypad_code_lock

Overview:
- Consumes the one-cycle key_valid/key_value strobes from keypad_scanner and implements a PIN-entry lock.
- Buffers digits, checks them against a stored code on Enter, and drives the unlock output for a fixed hold time.
- After MAX_FAILS consecutive wrong codes it enters a timed lockout.
- Sits between the scanner and the door actuator / status LEDs / 7-segment display driver.

Parameters:
- CODE_LEN, 4: digits per code, range 1..8.
- CLK_HZ, 50000000: clock frequency, used to derive the 1 ms tick.
- ENTRY_TIMEOUT_MS, 5000: idle time in ENTRY before the buffer is discarded.
- UNLOCK_MS, 3000: unlocked hold time.
- MAX_FAILS, 3: consecutive wrong codes that trigger lockout.
- LOCKOUT_MS, 10000: lockout duration.
- DEFAULT_CODE, 16'h1234: BCD code loaded at reset, width 4*CODE_LEN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- key_valid  in  1  one-cycle key strobe from the scanner
- key_value  in  4  key code; valid only when key_valid=1
- entry_digits  out  4*CODE_LEN  entered BCD digits; newest digit in bits [3:0]
- digit_count  out  $clog2(CODE_LEN+1)  number of digits currently held
- unlocked  out  1  high for the whole OPEN state
- locked_out  out  1  high for the whole LOCKOUT state
- good_code  out  1  one-cycle pulse on a correct code
- bad_code  out  1  one-cycle pulse on a wrong code
- fail_count  out  $clog2(MAX_FAILS+1)  consecutive failures
- prog_active  out  1  high in PROG; tied 0 when the optional feature is absent

Behaviour:
- Reset (synchronous): state=IDLE; entry_digits=0; digit_count=0; all 1-bit outputs 0; fail_count=0; code register=DEFAULT_CODE; ms timer=0.
- Key classes:
  - 0x0-0x9: digit.
  - 0xA: ENTER.
  - 0xB: BACK.
  - 0xE: CLEAR.
  - 0xC: PROG; treated as a no-op without the optional feature.
  - 0xD, 0xF: always ignored.
- Every key acts in the cycle after key_valid is sampled high (registered decision).
- IDLE:
  - digit -> load it as entry_digits[3:0], digit_count=1, go to ENTRY.
  - Any other key -> ignored.
- ENTRY:
  - digit: shift left 4 bits and insert the new digit, digit_count++. If digit_count==CODE_LEN the digit is dropped and the count holds.
  - BACK: shift right 4 bits, digit_count--. If the count reaches 0 -> IDLE.
  - CLEAR: zero the buffer and count -> IDLE.
  - ENTER -> CHECK.
  - Timeout: timer restarts on every key_valid. Reaching ENTRY_TIMEOUT_MS clears the buffer -> IDLE. If a key arrives in the expiry cycle, the key wins.
- CHECK (exactly 1 cycle):
  - Match condition: digit_count==CODE_LEN and entry_digits==code.
  - Match -> good_code pulse, fail_count=0, go to OPEN.
  - Mismatch -> bad_code pulse, fail_count++. If the new fail_count==MAX_FAILS go to LOCKOUT, else go to IDLE.
  - Buffer and count cleared on leaving CHECK.
  - key_valid arriving during CHECK is dropped.
- OPEN:
  - unlocked=1; timer restarted on entry.
  - After UNLOCK_MS, or on CLEAR -> IDLE.
  - Digits, ENTER and BACK are ignored.
- LOCKOUT:
  - locked_out=1; all keys ignored.
  - After LOCKOUT_MS -> IDLE with fail_count=0.
- Timer: ms_tick_gen produces a 1-cycle tick every CLK_HZ/1000 clocks. The ms counter clears on every state change and is sized for the largest *_MS parameter.
- Reset asserted in any state returns everything to reset values on the next edge, including the code register (a programmed code is lost).

Optional Feature:
- Macro: KEYPAD_LOCK_PROGRAM_EN.
- Defined:
  - PROG in OPEN -> PROG state, prog_active=1, buffer cleared, timer restarted.
  - Digits, BACK and timeout behave as in ENTRY; timeout or CLEAR aborts to IDLE and the code is unchanged.
  - ENTER with digit_count==CODE_LEN writes entry_digits to the code register and emits good_code -> IDLE.
  - ENTER with fewer digits emits bad_code -> IDLE, code unchanged, fail_count unaffected.
- Undefined: no PROG state, key 0xC ignored everywhere, prog_active tied 0.

Decomposition:
- keypad_pkg holds:
  - Key constants: KEY_ENTER=4'hA, KEY_BACK=4'hB, KEY_PROG=4'hC, KEY_CLEAR=4'hE, KEY_NONE=4'hF.
  - Lock state encoding: IDLE, ENTRY, CHECK, OPEN, LOCKOUT, PROG.
- Sub-module ms_tick_gen (param CLK_HZ, ports clk/reset/tick). It is reusable by the scanner's timers.

Test Plan (CLK_HZ=1000 so 1 ms = 1 clock, ENTRY_TIMEOUT_MS=20, UNLOCK_MS=10, LOCKOUT_MS=30, MAX_FAILS=3):
- Keys 1,2,3,4,A -> good_code pulse once, unlocked=1 for 10 cycles then 0, fail_count=0.
- Keys 1,2,3,5,A three times -> bad_code ×3; locked_out=1 after the third; keys 1,2,3,4,A during lockout are ignored; locked_out falls after 30 ms; then 1,2,3,4,A unlocks.
- Keys 1,2,3,4,5 -> digit_count=4, entry_digits=16'h1234; then B,9 -> 16'h1239; then E -> count 0, state IDLE.
- Keys 1,2 then silence 20 ms -> buffer cleared, IDLE; a following A is ignored (no pulse).
- Keys 1,2,A (short code) -> bad_code, fail_count=1; then 1,2,3,4,A -> fail_count=0, unlocked.
- With KEYPAD_LOCK_PROGRAM_EN: unlock, then C,9,8,7,6,A -> good_code; 1,2,3,4,A -> bad_code; 9,8,7,6,A -> unlocked. Reset restores code 1234.
